// File: rtl/lfsr_checker.sv
// Receive-side checker for the 16-bit Fibonacci LFSR pattern (taps 16/14/13/11).
// It seeds a predictor from the incoming stream and confirms a run of correct
// predictions before declaring lock. Once locked, it counts mismatched words
// against a free-running predictor.
module lfsr_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      data_in,
    input  logic             valid_in,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int LC_W = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_pred;
    logic [15:0]       w_pred_nxt;
    logic [MC_W-1:0]   r_match_cnt;
    logic [MC_W-1:0]   w_match_nxt;
    logic [MC_W-1:0]   w_match_inc;
    logic [LC_W-1:0]   r_miss_cnt;
    logic [LC_W-1:0]   w_miss_nxt;
    logic [LC_W-1:0]   w_miss_inc;
    logic              w_count_evt;
    logic              r_locked;
    logic              r_err;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // One step of the generator polynomial.
    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    assign w_match_inc = r_match_cnt + MC_W'(1);
    assign w_miss_inc  = r_miss_cnt + LC_W'(1);

    // Next-state, predictor and counter decisions for the current word.
    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_count_evt = 1'b0;
        if (valid_in) begin
            case (r_state)
                HUNT: begin
                    // Zero can never occur in the sequence, so it is not a valid seed.
                    if (data_in != 16'h0000) begin
                        w_pred_nxt  = lfsr_next(data_in);
                        w_match_nxt = '0;
                        w_state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data_in == r_pred) begin
                        w_pred_nxt  = lfsr_next(r_pred);
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == MC_W'(LOCK_COUNT)) begin
                            w_state_nxt = LOCKED;
                        end
                    end else if (data_in != 16'h0000) begin
                        w_pred_nxt  = lfsr_next(data_in);
                        w_match_nxt = '0;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // The predictor free-runs so a bad word cannot corrupt it.
                    w_pred_nxt = lfsr_next(r_pred);
                    if (data_in == r_pred) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_count_evt = 1'b1;
                        if (w_miss_inc == LC_W'(LOSS_COUNT)) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end
    end

    // Error counter update: a clear takes effect first, then this cycle's error counts.
    always_comb begin
        w_cnt_nxt = r_err_count;
        if (clear_cnt) begin
            w_cnt_nxt = w_count_evt ? CNT_W'(1) : '0;
        end else if (w_count_evt) begin
            w_cnt_nxt = sat_inc(r_err_count);
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_pred      <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_count_evt;
            r_err_count <= w_cnt_nxt;
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios, then random traffic, all scored
// against a behavioural model of the checker's rules.
module tb_lfsr_checker;

    localparam int LOCK_COUNT = 4;
    localparam int LOSS_COUNT = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [15:0]      data_in = 16'h0000;
    logic             valid_in = 1'b0;
    logic             clear_cnt = 1'b0;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state: mode 0 = hunting, 1 = verifying, 2 = locked.
    int          m_mode   = 0;
    logic [15:0] m_pred   = 16'h0000;
    int          m_run    = 0;
    int          m_miss   = 0;
    int          m_cnt    = 0;
    int          m_err    = 0;
    int          m_locked = 0;

    // Word the generator will produce next.
    logic [15:0] gen = 16'hACE1;

    lfsr_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_COUNT(LOSS_COUNT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .clear_cnt(clear_cnt),
        .locked   (locked),
        .err      (err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] x);
        logic fb;
        fb = x[15] ^ x[13] ^ x[12] ^ x[10];
        return (x << 1) | {15'd0, fb};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [15:0] d, input logic c);
        int counted;
        counted = 0;
        if (!r) begin
            m_mode = 0; m_pred = 16'h0000; m_run = 0; m_miss = 0;
            m_cnt = 0; m_err = 0; m_locked = 0;
            return;
        end
        if (v) begin
            if (m_mode == 0) begin
                if (d != 16'h0000) begin
                    m_pred = nxt(d); m_run = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (d == m_pred) begin
                    m_pred = nxt(m_pred);
                    m_run  = m_run + 1;
                    if (m_run == LOCK_COUNT) m_mode = 2;
                end else if (d != 16'h0000) begin
                    m_pred = nxt(d); m_run = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (d == m_pred) begin
                    m_miss = 0;
                end else begin
                    counted = 1;
                    m_miss  = m_miss + 1;
                    if (m_miss == LOSS_COUNT) begin
                        m_mode = 0; m_miss = 0;
                    end
                end
                m_pred = nxt(m_pred);
            end
        end
        if (c) m_cnt = counted;
        else if (counted != 0) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        m_err    = counted;
        m_locked = (m_mode == 2) ? 1 : 0;
    endtask

    // Apply one cycle of inputs, advance the model, compare #1 after the edge.
    task automatic cyc(input logic v, input logic [15:0] d, input logic c, input logic r);
        rst = r; valid_in = v; data_in = d; clear_cnt = c;
        @(posedge clk);
        model_step(r, v, d, c);
        #1;
        check_val("locked", 32'(locked), 32'(m_locked));
        check_val("err", 32'(err), 32'(m_err));
        check_val("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic send_good();
        cyc(1'b1, gen, 1'b0, 1'b1);
        gen = nxt(gen);
    endtask

    task automatic send_bad(input logic [15:0] mask, input logic c);
        cyc(1'b1, gen ^ mask, c, 1'b1);
        gen = nxt(gen);
    endtask

    initial begin
        // Reset held with valid traffic present.
        cyc(1'b1, 16'hACE1, 1'b0, 1'b0);
        cyc(1'b1, 16'hACE1, 1'b0, 1'b0);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_cnt", 32'(err_count), 32'd0);

        // Lock-up: first word after reset is the seed, lock follows the 5th word.
        gen = 16'hACE1;
        check_val("seq_w1", 32'(nxt(16'hACE1)), 32'h59C3);
        for (int i = 0; i < 4; i++) send_good();
        check_val("lock_after4", 32'(locked), 32'd0);
        send_good();
        check_val("lock_after5", 32'(locked), 32'd1);

        // One bad word while locked, then clean words.
        send_bad(16'h0001, 1'b0);
        check_val("single_err", 32'(err), 32'd1);
        check_val("single_cnt", 32'(err_count), 32'd1);
        for (int i = 0; i < 3; i++) send_good();
        check_val("single_err_gone", 32'(err), 32'd0);
        check_val("single_still_locked", 32'(locked), 32'd1);

        // Clear alone, then loss of lock after LOSS_COUNT bad words.
        cyc(1'b0, 16'h1234, 1'b1, 1'b1);
        check_val("clear_alone", 32'(err_count), 32'd0);
        for (int i = 0; i < 3; i++) send_bad(16'h8000, 1'b0);
        check_val("loss_locked3", 32'(locked), 32'd1);
        send_bad(16'h8000, 1'b0);
        check_val("loss_err4", 32'(err), 32'd1);
        check_val("loss_unlocked", 32'(locked), 32'd0);
        check_val("loss_cnt", 32'(err_count), 32'd4);
        gen = 16'hACE1;
        for (int i = 0; i < 5; i++) send_good();
        check_val("relock", 32'(locked), 32'd1);
        check_val("relock_cnt", 32'(err_count), 32'd4);

        // Zero word in HUNT, then lock-up with gaps carrying garbage.
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        gen = 16'hACE1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_val("gap_lock_before5", 32'(locked), 32'd0);
            send_good();
            cyc(1'b0, 16'($urandom), 1'b0, 1'b1);
        end
        check_val("gap_lock", 32'(locked), 32'd1);

        // Saturation and clear-with-error.
        for (int i = 0; i < 20; i++) begin
            send_bad(16'h0100, 1'b0);
            send_good();
        end
        check_val("sat_cnt", 32'(err_count), 32'(CNT_MAX));
        check_val("sat_locked", 32'(locked), 32'd1);
        send_bad(16'h0010, 1'b1);
        check_val("clear_with_err", 32'(err_count), 32'd1);
        cyc(1'b0, 16'hFFFF, 1'b1, 1'b1);
        check_val("clear_only", 32'(err_count), 32'd0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            int          sel;
            logic        c;
            logic        r;
            logic [15:0] m;
            sel = int'($urandom_range(0, 99));
            c   = ($urandom_range(0, 99) < 3);
            r   = ($urandom_range(0, 999) >= 5);
            m   = 16'($urandom);
            if (m == 16'h0000) m = 16'h0004;
            if (sel < 60) begin
                cyc(1'b1, gen, c, r); gen = nxt(gen);
            end else if (sel < 70) begin
                cyc(1'b1, gen ^ m, c, r); gen = nxt(gen);
            end else if (sel < 78) begin
                cyc(1'b0, 16'($urandom), c, r);
            end else if (sel < 82) begin
                cyc(1'b1, 16'h0000, c, r);
            end else if (sel < 86) begin
                gen = 16'hACE1;
                cyc(1'b1, gen, c, r); gen = nxt(gen);
            end else begin
                gen = m;
                cyc(1'b1, gen, c, r); gen = nxt(gen);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
